// File: rtl/pipeline_pkg.sv
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared widths, decoded-instruction record and slot state
//               encoding for the decode-to-execute operand stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] rs;
        logic [ADDR_W-1:0] rt;
        logic [ADDR_W-1:0] rd;
        logic              we;
    } decoded_instr_t;

    typedef enum logic [0:0] {
        F_EMPTY = 1'b0,
        F_HELD  = 1'b1
    } f_state_t;

endpackage

`default_nettype wire

// File: rtl/operand_fetch_if.sv
// ============================================================================
// Module      : operand_fetch_if
// Description : Decode, execute, write-back and reg_file buses of the operand
//               fetch stage. master = operand_fetch, slave = its environment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface operand_fetch_if #(
    parameter int DATA_W = pipeline_pkg::DATA_W,
    parameter int ADDR_W = pipeline_pkg::ADDR_W
);
    localparam int NUM_REGS = 1 << ADDR_W;

    logic                id_valid;
    logic                id_ready;
    logic [ADDR_W-1:0]   id_rs;
    logic [ADDR_W-1:0]   id_rt;
    logic [ADDR_W-1:0]   id_rd;
    logic                id_we;

    logic                ex_valid;
    logic                ex_ready;
    logic [DATA_W-1:0]   ex_op1;
    logic [DATA_W-1:0]   ex_op2;
    logic [ADDR_W-1:0]   ex_rd;
    logic                ex_we;

    logic                wb_valid;
    logic [ADDR_W-1:0]   wb_reg;
    logic [DATA_W-1:0]   wb_data;

    logic [ADDR_W-1:0]   PR1;
    logic [ADDR_W-1:0]   PR2;
    logic [DATA_W-1:0]   RD1;
    logic [DATA_W-1:0]   RD2;
    logic                write;
    logic [ADDR_W-1:0]   WR;
    logic [DATA_W-1:0]   WD;

    logic [NUM_REGS-1:0] sb_pending;

    modport master (
        input  id_valid, id_rs, id_rt, id_rd, id_we,
        output id_ready,
        output ex_valid, ex_op1, ex_op2, ex_rd, ex_we,
        input  ex_ready,
        input  wb_valid, wb_reg, wb_data,
        output PR1, PR2,
        input  RD1, RD2,
        output write, WR, WD,
        output sb_pending
    );

    modport slave (
        output id_valid, id_rs, id_rt, id_rd, id_we,
        input  id_ready,
        input  ex_valid, ex_op1, ex_op2, ex_rd, ex_we,
        output ex_ready,
        output wb_valid, wb_reg, wb_data,
        input  PR1, PR2,
        output RD1, RD2,
        input  write, WR, WD,
        input  sb_pending
    );

endinterface

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// Module      : reg_scoreboard
// Description : One pending bit per register with three read-out ports.
//               Set beats clear on the same register; r0 is never pending.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_scoreboard
    import pipeline_pkg::*;
(
    input  wire                 clk,
    input  wire                 rst,
    input  wire                 i_set_en,
    input  wire  [ADDR_W-1:0]   i_set_addr,
    input  wire                 i_clr_en,
    input  wire  [ADDR_W-1:0]   i_clr_addr,
    input  wire  [ADDR_W-1:0]   i_q0_addr,
    input  wire  [ADDR_W-1:0]   i_q1_addr,
    input  wire  [ADDR_W-1:0]   i_q2_addr,
    output logic                o_q0_pending,
    output logic                o_q1_pending,
    output logic                o_q2_pending,
    output logic [NUM_REGS-1:0] o_pending
);

    logic [NUM_REGS-1:0] w_pending;

    assign w_pending[0] = 1'b0;

    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_entry
        logic r_bit;

        // A newly issued writer must stay visible even if an older write-back
        // to the same register retires in the same cycle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_bit <= 1'b0;
            end else if (i_set_en && (i_set_addr == ADDR_W'(gi))) begin
                r_bit <= 1'b1;
            end else if (i_clr_en && (i_clr_addr == ADDR_W'(gi))) begin
                r_bit <= 1'b0;
            end
        end

        assign w_pending[gi] = r_bit;
    end

    assign o_q0_pending = w_pending[i_q0_addr];
    assign o_q1_pending = w_pending[i_q1_addr];
    assign o_q2_pending = w_pending[i_q2_addr];
    assign o_pending    = w_pending;

endmodule

`default_nettype wire

// File: rtl/operand_fetch.sv
// ============================================================================
// Module      : operand_fetch
// Description : Decode-to-execute operand stage: reads reg_file, tracks
//               in-flight writers, stalls on RAW/WAW, bypasses write-back.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_fetch
    import pipeline_pkg::*;
(
    input  wire             clk,
    input  wire             reset,
    operand_fetch_if.master bus
);

    f_state_t            r_f_state;
    f_state_t            w_f_state_nxt;
    decoded_instr_t      r_f;
    decoded_instr_t      w_f_nxt;
    decoded_instr_t      w_id_instr;

    logic                r_ex_valid;
    logic                r_ex_we;
    logic [ADDR_W-1:0]   r_ex_rd;
    logic [DATA_W-1:0]   r_ex_op1;
    logic [DATA_W-1:0]   r_ex_op2;

    logic                w_f_valid;
    logic                w_write;
    logic                w_hit_rs;
    logic                w_hit_rt;
    logic                w_hit_rd;
    logic                w_pend_rs;
    logic                w_pend_rt;
    logic                w_pend_rd;
    logic                w_raw1;
    logic                w_raw2;
    logic                w_waw;
    logic                w_stall;
    logic                w_issue;
    logic                w_id_ready;
    logic                w_accept;
    logic                w_sb_set;
    logic [DATA_W-1:0]   w_op1;
    logic [DATA_W-1:0]   w_op2;
    logic [NUM_REGS-1:0] w_sb_pending;

    // Write port is a pure pass-through; r0 writes are suppressed.
    assign w_write   = bus.wb_valid && (bus.wb_reg != REG_ZERO);
    assign bus.write = w_write;
    assign bus.WR    = bus.wb_reg;
    assign bus.WD    = bus.wb_data;

    assign w_f_valid = (r_f_state == F_HELD);
    assign bus.PR1   = w_f_valid ? r_f.rs : REG_ZERO;
    assign bus.PR2   = w_f_valid ? r_f.rt : REG_ZERO;

    assign w_hit_rs  = w_write && (bus.wb_reg == r_f.rs);
    assign w_hit_rt  = w_write && (bus.wb_reg == r_f.rt);
    assign w_hit_rd  = w_write && (bus.wb_reg == r_f.rd);

    // A pending source whose write-back is on the bus right now is not a
    // hazard: the bypass below supplies the value at the same edge.
    assign w_raw1  = w_pend_rs && (r_f.rs != REG_ZERO) && !w_hit_rs;
    assign w_raw2  = w_pend_rt && (r_f.rt != REG_ZERO) && !w_hit_rt;
    assign w_waw   = r_f.we && (r_f.rd != REG_ZERO) && w_pend_rd && !w_hit_rd;
    assign w_stall = w_raw1 || w_raw2 || w_waw;

    assign w_op1 = w_hit_rs ? bus.wb_data : bus.RD1;
    assign w_op2 = w_hit_rt ? bus.wb_data : bus.RD2;

    assign w_issue    = w_f_valid && !w_stall && (!r_ex_valid || bus.ex_ready);
    assign w_id_ready = !w_f_valid || w_issue;
    assign w_accept   = bus.id_valid && w_id_ready;
    assign w_sb_set   = w_issue && r_f.we && (r_f.rd != REG_ZERO);

    assign w_id_instr = '{rs: bus.id_rs, rt: bus.id_rt, rd: bus.id_rd, we: bus.id_we};

    reg_scoreboard u_scoreboard (
        .clk          (clk),
        .rst          (reset),
        .i_set_en     (w_sb_set),
        .i_set_addr   (r_f.rd),
        .i_clr_en     (w_write),
        .i_clr_addr   (bus.wb_reg),
        .i_q0_addr    (r_f.rs),
        .i_q1_addr    (r_f.rt),
        .i_q2_addr    (r_f.rd),
        .o_q0_pending (w_pend_rs),
        .o_q1_pending (w_pend_rt),
        .o_q2_pending (w_pend_rd),
        .o_pending    (w_sb_pending)
    );

    always_comb begin
        w_f_state_nxt = r_f_state;
        w_f_nxt       = r_f;
        case (r_f_state)
            F_EMPTY: begin
                if (w_accept) begin
                    w_f_state_nxt = F_HELD;
                    w_f_nxt       = w_id_instr;
                end
            end
            F_HELD: begin
                if (w_accept) begin
                    w_f_nxt = w_id_instr;
                end else if (w_issue) begin
                    w_f_state_nxt = F_EMPTY;
                    w_f_nxt       = '0;
                end
            end
            default: begin
                w_f_state_nxt = F_EMPTY;
                w_f_nxt       = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_f_state <= F_EMPTY;
            r_f       <= '0;
        end else begin
            r_f_state <= w_f_state_nxt;
            r_f       <= w_f_nxt;
        end
    end

    // EX holds its contents while execute back-pressures.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_valid <= 1'b0;
            r_ex_we    <= 1'b0;
            r_ex_rd    <= '0;
            r_ex_op1   <= '0;
            r_ex_op2   <= '0;
        end else if (w_issue) begin
            r_ex_valid <= 1'b1;
            r_ex_we    <= r_f.we;
            r_ex_rd    <= r_f.rd;
            r_ex_op1   <= w_op1;
            r_ex_op2   <= w_op2;
        end else if (bus.ex_ready) begin
            r_ex_valid <= 1'b0;
        end
    end

    assign bus.id_ready   = w_id_ready;
    assign bus.ex_valid   = r_ex_valid;
    assign bus.ex_we      = r_ex_we;
    assign bus.ex_rd      = r_ex_rd;
    assign bus.ex_op1     = r_ex_op1;
    assign bus.ex_op2     = r_ex_op2;
    assign bus.sb_pending = w_sb_pending;

endmodule

`default_nettype wire
